// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the MAC result collector slice.
//   - default accumulator width / lane count / round counter width
//   - collector FSM state encoding (IDLE=0, COLLECT=1, DRAIN=2)
//   - lane index typedef sized for the default lane count
package mac_pkg;

    localparam int ACC_W_DEF  = 16;
    localparam int N_MACS_DEF = 4;
    localparam int RND_W_DEF  = 8;
    localparam int LANE_W_DEF = (N_MACS_DEF > 1) ? $clog2(N_MACS_DEF) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } coll_state_t;

    typedef logic [LANE_W_DEF-1:0] lane_idx_t;

endpackage

// File: rtl/mac_lane_capture.sv
// mac_lane_capture: one MAC lane's capture slot.
//   Detects the rising edge of the lane's valid, latches the accumulator into
//   a hold register and raises the lane flag. A rise while the flag is still
//   set (lane not drained) is dropped and reported as a one-cycle drop pulse.
// Ports:
//   clk, rst        clock, async active-high reset
//   clear           synchronous clear, highest priority
//   valid_in        lane valid from the array
//   acc_in          lane accumulator value
//   drain_ack       this lane's beat is being accepted downstream this cycle
//   capture         rise accepted this cycle (comb)
//   drop            rise lost because the slot is still occupied (comb)
//   flag            slot holds an undrained value
//   hold            captured value
module mac_lane_capture #(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             valid_in,
    input  logic [ACC_W-1:0] acc_in,
    input  logic             drain_ack,
    output logic             capture,
    output logic             drop,
    output logic             flag,
    output logic [ACC_W-1:0] hold
);

    logic valid_d;
    logic rise;

    assign rise = valid_in & ~valid_d;
    // A same-cycle drain frees the slot first, so the new value becomes
    // next round's entry instead of an overflow.
    assign capture = rise & (~flag | drain_ack);
    assign drop    = rise & flag & ~drain_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_d <= 1'b0;
            flag    <= 1'b0;
            hold    <= '0;
        end else if (clear) begin
            valid_d <= 1'b0;
            flag    <= 1'b0;
            hold    <= '0;
        end else begin
            valid_d <= valid_in;
            if (capture) begin
                flag <= 1'b1;
                hold <= acc_in;
            end else if (drain_ack) begin
                flag <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mac_result_collector.sv
// mac_result_collector: captures per-lane MAC results on valid rising edges
// and replays them as one lane-ascending valid/ready stream, out_last marking
// the end of each round. The array never sees backpressure.
// Optional build macro: MAC_COLLECT_RELU_EN (ReLU applied to out_data only).
// Ports:
//   clk, rst      clock, async active-high reset
//   clear         synchronous clear (same effect as reset)
//   valid_in      per-lane valid, acc_in packed lane results (lane i at i*ACC_W)
//   busy_in       array busy; falling edge closes a partial round
//   out_valid/out_ready/out_data/out_lane/out_last  serial result stream
//   round_cnt     completed rounds (wraps)
//   overflow      sticky: a capture was lost
//   collecting    FSM is in COLLECT
module mac_result_collector
    import mac_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int N_MACS = N_MACS_DEF,
    parameter int LANE_W = (N_MACS > 1) ? $clog2(N_MACS) : 1,
    parameter int RND_W  = RND_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic [N_MACS-1:0]       valid_in,
    input  logic [N_MACS*ACC_W-1:0] acc_in,
    input  logic                    busy_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_data,
    output logic [LANE_W-1:0]       out_lane,
    output logic                    out_last,
    output logic [RND_W-1:0]        round_cnt,
    output logic                    overflow,
    output logic                    collecting
);

    coll_state_t                   state;
    logic [N_MACS-1:0]             flags, capture, drop, ack, mask, pending;
    logic [N_MACS-1:0]             flags_upd, flags_after;
    logic [N_MACS-1:0][ACC_W-1:0]  hold;
    logic                          busy_d, bfall, hs, in_drain;
    logic [LANE_W-1:0]             sel;
    logic                          sel_found, sel_last;

    genvar gi;
    generate
        for (gi = 0; gi < N_MACS; gi++) begin : g_lane
            mac_lane_capture #(.ACC_W(ACC_W)) u_lane (
                .clk       (clk),
                .rst       (rst),
                .clear     (clear),
                .valid_in  (valid_in[gi]),
                .acc_in    (acc_in[gi*ACC_W +: ACC_W]),
                .drain_ack (ack[gi]),
                .capture   (capture[gi]),
                .drop      (drop[gi]),
                .flag      (flags[gi]),
                .hold      (hold[gi])
            );
        end
    endgenerate

    assign in_drain    = (state == ST_DRAIN);
    assign bfall       = busy_d & ~busy_in;
    // Round mask freezes membership at DRAIN entry; lanes recaptured after
    // being sent carry a flag but are excluded until the next round.
    assign pending     = in_drain ? (flags & mask) : '0;
    assign hs          = in_drain & out_ready;
    assign flags_upd   = flags | capture;
    assign flags_after = (flags & ~ack) | capture;

    // Lowest pending lane is presented; last when nothing above it remains.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        sel_last  = 1'b1;
        for (int i = 0; i < N_MACS; i++) begin
            if (pending[i] && !sel_found) begin
                sel       = LANE_W'(i);
                sel_found = 1'b1;
            end
        end
        for (int i = 0; i < N_MACS; i++) begin
            if (pending[i] && (i > int'(sel))) sel_last = 1'b0;
        end
    end

    always_comb begin
        ack = '0;
        if (hs) ack[sel] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            mask      <= '0;
            busy_d    <= 1'b0;
            round_cnt <= '0;
            overflow  <= 1'b0;
        end else if (clear) begin
            state     <= ST_IDLE;
            mask      <= '0;
            busy_d    <= 1'b0;
            round_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            busy_d <= busy_in;
            if (|drop) overflow <= 1'b1;
            case (state)
                ST_IDLE: begin
                    // A lone capture coinciding with bfall still closes its round.
                    if (|flags_upd) begin
                        if ((&flags_upd) || bfall) begin
                            state <= ST_DRAIN;
                            mask  <= flags_upd;
                        end else begin
                            state <= ST_COLLECT;
                        end
                    end
                end
                ST_COLLECT: begin
                    if ((&flags_upd) || (bfall && (|flags_upd))) begin
                        state <= ST_DRAIN;
                        mask  <= flags_upd;
                    end
                end
                ST_DRAIN: begin
                    if (hs) begin
                        mask <= mask & ~ack;
                        if (sel_last) begin
                            round_cnt <= round_cnt + 1'b1;
                            state     <= (|flags_after) ? ST_COLLECT : ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid  = in_drain;
    assign out_lane   = in_drain ? sel : '0;
    assign out_last   = in_drain & sel_last;
    assign collecting = (state == ST_COLLECT);

`ifdef MAC_COLLECT_RELU_EN
    assign out_data = (!in_drain || hold[sel][ACC_W-1]) ? '0 : hold[sel];
`else
    assign out_data = in_drain ? hold[sel] : '0;
`endif

endmodule

// File: tb/tb_mac_result_collector.sv
module tb_mac_result_collector;

    localparam int ACC_W = 16;
    localparam int N     = 4;
    localparam int LW    = 2;
    localparam int RW    = 8;

    logic              clk = 1'b0;
    logic              rst, clear, busy_in, out_ready;
    logic [N-1:0]      valid_in;
    logic [N*ACC_W-1:0] acc_in;
    logic              out_valid, out_last, overflow, collecting;
    logic [ACC_W-1:0]  out_data;
    logic [LW-1:0]     out_lane;
    logic [RW-1:0]     round_cnt;

    mac_result_collector #(.ACC_W(ACC_W), .N_MACS(N), .LANE_W(LW), .RND_W(RW)) dut (
        .clk(clk), .rst(rst), .clear(clear), .valid_in(valid_in), .acc_in(acc_in),
        .busy_in(busy_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_lane(out_lane), .out_last(out_last),
        .round_cnt(round_cnt), .overflow(overflow), .collecting(collecting)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_rounds = 0;
    bit exp_ovf = 1'b0;

    typedef struct {
        logic [3:0]        lanes;
        logic [3:0][15:0]  vals;
        bit                partial;
        int                stall_beat;
        logic [3:0][15:0]  exp_data;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_out(input logic [15:0] v);
`ifdef MAC_COLLECT_RELU_EN
        return v[15] ? 16'h0 : v;
`else
        return v;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_lane(input int l, input logic [15:0] v);
        acc_in[l*16 +: 16] = v;
        valid_in[l] = 1'b1;
        tick();
        valid_in[l] = 1'b0;
    endtask

    task automatic close_partial();
        busy_in = 1'b0;
        tick();
        busy_in = 1'b1;
    endtask

    // Expected stream: every lane of the round, ascending, last on the highest.
    task automatic drain(input string tag, input logic [3:0] lanes, input logic [3:0][15:0] exp,
                         input int stall_beat, input int inj_beat, input logic [15:0] inj_val);
        int waited = 0;
        int beat = 0;
        int hi = 0;
        for (int l = 0; l < N; l++) if (lanes[l]) hi = l;
        while (!out_valid && waited < 20) begin
            tick();
            waited++;
        end
        check({tag, " first valid"}, {63'd0, out_valid}, 64'd1);
        if (!out_valid) return;
        for (int l = 0; l < N; l++) begin
            if (!lanes[l]) continue;
            if (beat == stall_beat) begin
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    check({tag, " stall hold"}, {out_valid, out_lane, out_last, out_data},
                          {1'b1, 2'(l), (l == hi), exp[l]});
                end
            end
            out_ready = 1'b1;
            check({tag, " beat"}, {out_valid, out_lane, out_last, out_data},
                  {1'b1, 2'(l), (l == hi), exp[l]});
            if (beat == inj_beat) begin
                acc_in[l*16 +: 16] = inj_val;
                valid_in[l] = 1'b1;
            end
            tick();
            valid_in = '0;
            beat++;
        end
        out_ready = 1'b0;
        exp_rounds++;
        check({tag, " valid low after round"}, {63'd0, out_valid}, 64'd0);
        check({tag, " round_cnt"}, {56'd0, round_cnt}, {56'd0, 8'(exp_rounds)});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]       lanes;
        logic [3:0][15:0] vals, expv;
        int               stall, cnt, lo;

        rst = 1'b1; clear = 1'b0; busy_in = 1'b1; out_ready = 1'b0;
        valid_in = '0; acc_in = '0;
        #1;
        check("reset out_valid",  {63'd0, out_valid},  64'd0);
        check("reset out_data",   {48'd0, out_data},   64'd0);
        check("reset out_lane",   {62'd0, out_lane},   64'd0);
        check("reset out_last",   {63'd0, out_last},   64'd0);
        check("reset round_cnt",  {56'd0, round_cnt},  64'd0);
        check("reset overflow",   {63'd0, overflow},   64'd0);
        check("reset collecting", {63'd0, collecting}, 64'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        vecs[0] = '{4'b1111, {16'd70, 16'd50, 16'd30, 16'd20}, 1'b0, -1, {16'd70, 16'd50, 16'd30, 16'd20}};
        vecs[1] = '{4'b1111, {16'd70, 16'd50, 16'd30, 16'd20}, 1'b0,  1, {16'd70, 16'd50, 16'd30, 16'd20}};
        vecs[2] = '{4'b0101, {16'd0,  16'd50, 16'd0,  16'd20}, 1'b1, -1, {16'd0,  16'd50, 16'd0,  16'd20}};
`ifdef MAC_COLLECT_RELU_EN
        vecs[3] = '{4'b1111, {16'd70, 16'hFFFB, 16'd30, 16'hFFEC}, 1'b0, -1, {16'd70, 16'd0, 16'd30, 16'd0}};
        vecs[4] = '{4'b1000, {16'hFFFF, 16'd0, 16'd0, 16'd0}, 1'b1, -1, {16'd0, 16'd0, 16'd0, 16'd0}};
`else
        vecs[3] = '{4'b1111, {16'd70, 16'hFFFB, 16'd30, 16'hFFEC}, 1'b0, -1, {16'd70, 16'hFFFB, 16'd30, 16'hFFEC}};
        vecs[4] = '{4'b1000, {16'hFFFF, 16'd0, 16'd0, 16'd0}, 1'b1, -1, {16'hFFFF, 16'd0, 16'd0, 16'd0}};
`endif
        vecs[5] = '{4'b0110, {16'd0, 16'd8, 16'd7, 16'd0}, 1'b1, 0, {16'd0, 16'd8, 16'd7, 16'd0}};

        for (int v = 0; v < 6; v++) begin
            bit first = 1'b1;
            for (int l = 0; l < N; l++) begin
                if (vecs[v].lanes[l]) begin
                    pulse_lane(l, vecs[v].vals[l]);
                    if (first) check("collecting after first capture", {63'd0, collecting}, 64'd1);
                    first = 1'b0;
                end
            end
            if (vecs[v].partial) close_partial();
            drain($sformatf("vec%0d", v), vecs[v].lanes, vecs[v].exp_data, vecs[v].stall_beat, -1, 16'd0);
        end
        check("overflow clean after table", {63'd0, overflow}, 64'd0);

        // Overflow: second rise on an undrained lane is lost, first value kept.
        pulse_lane(1, 16'd30);
        tick();
        pulse_lane(1, 16'd99);
        check("overflow set", {63'd0, overflow}, 64'd1);
        close_partial();
        drain("ovf", 4'b0010, {16'd0, 16'd0, 16'd30, 16'd0}, -1, -1, 16'd0);
        pulse_lane(0, 16'd5);
        close_partial();
        drain("ovf2", 4'b0001, {16'd0, 16'd0, 16'd0, 16'd5}, -1, -1, 16'd0);
        check("overflow sticky", {63'd0, overflow}, 64'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        exp_rounds = 0;
        check("clear overflow",  {63'd0, overflow},  64'd0);
        check("clear round_cnt", {56'd0, round_cnt}, 64'd0);

        // Handshake of lane 0 with a fresh capture on lane 0 in the same cycle.
        pulse_lane(0, 16'd1); pulse_lane(1, 16'd2); pulse_lane(2, 16'd3); pulse_lane(3, 16'd4);
        drain("recap", 4'b1111, {16'd4, 16'd3, 16'd2, 16'd1}, -1, 0, 16'd111);
        check("recap collecting", {63'd0, collecting}, 64'd1);
        check("recap no overflow", {63'd0, overflow}, 64'd0);
        close_partial();
        drain("recap next", 4'b0001, {16'd0, 16'd0, 16'd0, 16'd111}, -1, -1, 16'd0);

        // Random rounds against the round-level model.
        for (int r = 0; r < 40; r++) begin
            lanes = 4'($urandom_range(1, 15));
            cnt = 0; lo = -1;
            for (int l = 0; l < N; l++) begin
                vals[l] = 16'($urandom);
                expv[l] = exp_out(vals[l]);
                if (lanes[l]) begin
                    if (lo < 0) lo = l;
                    cnt++;
                    pulse_lane(l, vals[l]);
                    repeat ($urandom_range(0, 2)) tick();
                end
            end
            if ($urandom_range(0, 3) == 0) begin
                tick();
                pulse_lane(lo, 16'($urandom));
                exp_ovf = 1'b1;
            end
            close_partial();
            stall = int'($urandom_range(0, 4)) - 1;
            if (stall >= cnt) stall = -1;
            drain($sformatf("rnd%0d", r), lanes, expv, stall, -1, 16'd0);
            check("rnd overflow", {63'd0, overflow}, {63'd0, exp_ovf});
        end

        // Async reset in the middle of a drain.
        pulse_lane(0, 16'd20); pulse_lane(1, 16'd30); pulse_lane(2, 16'd50); pulse_lane(3, 16'd70);
        out_ready = 1'b1;
        check("mid beat0", {out_valid, out_lane, out_data}, {1'b1, 2'd0, 16'd20});
        tick();
        rst = 1'b1;
        #2;
        check("async rst out_valid",  {63'd0, out_valid},  64'd0);
        check("async rst out_data",   {48'd0, out_data},   64'd0);
        check("async rst out_last",   {63'd0, out_last},   64'd0);
        check("async rst round_cnt",  {56'd0, round_cnt},  64'd0);
        check("async rst overflow",   {63'd0, overflow},   64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("no residual beat", {62'd0, out_valid, collecting}, 64'd0);
        end
        out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
